// File: rtl/mac_lane_array.sv
// mac_lane_array: per-lane uint8 multiply with tail/unused lane masking, adder-tree reduction
// to one partial sum per accepted beat. Define MAC_TREE_PIPE_EN to register the first tree level.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start_i; in_ready low
// S_RUN   | accepting beats until the beat that covers the last element
// S_DRAIN | no new beats; waiting for the last-tagged sum to leave the pipe
module mac_lane_array #(
  parameter int ELEMS = 1000,
  parameter int LANES = 16,
  parameter int W_IN  = 16 + $clog2(LANES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [4:0]           lanes_i,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*LANES-1:0]   a_i,
  input  logic [8*LANES-1:0]   b_i,
  output logic                 ps_valid,
  output logic [W_IN-1:0]      partial_sum,
  output logic                 ps_last,
  output logic [4:0]           lanes_o,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam int CW = $clog2(ELEMS + LANES) + 1;

  state_t          state_q, state_d;
  logic [4:0]      lanes_q, lanes_d;
  logic [CW-1:0]   elem_cnt_q, elem_cnt_d;
  logic            lanes_legal;
  logic            accept;
  logic            beat_last;
  logic            start_ok;
  logic [LANES-1:0] lane_used;

  logic [15:0]     prod_q [LANES];
  logic            s1_valid_q, s1_last_q;
  logic            tail_valid, tail_last;
  logic [W_IN-1:0] tree_sum;

  logic [W_IN-1:0] ps_q;
  logic            ps_valid_q, ps_last_q;
  logic            done_q, cfg_err_q;

  always_comb begin
    case (lanes_i)
      5'd1, 5'd2, 5'd4, 5'd8, 5'd16: lanes_legal = (int'(lanes_i) <= LANES);
      default:                       lanes_legal = 1'b0;
    endcase
  end

  assign start_ok  = (state_q == S_IDLE) && start_i && lanes_legal;
  assign accept    = in_valid && in_ready;
  assign beat_last = (elem_cnt_q + CW'(lanes_q)) >= CW'(ELEMS);

  // Lane k carries element elem_cnt+k; lanes past the vector end contribute nothing.
  always_comb begin
    lane_used = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_used[k] = (k < int'(lanes_q)) && ((elem_cnt_q + CW'(k)) < CW'(ELEMS));
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok)                 state_d = S_RUN;
      S_RUN:   if (accept && beat_last)      state_d = S_DRAIN;
      S_DRAIN: if (ps_valid_q && ps_last_q)  state_d = S_IDLE;
      default:                               state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      S_RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_DRAIN: busy = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    lanes_d    = lanes_q;
    elem_cnt_d = elem_cnt_q;
    if (start_ok) begin
      lanes_d    = lanes_i;
      elem_cnt_d = '0;
    end else if (accept) begin
      elem_cnt_d = elem_cnt_q + CW'(lanes_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lanes_q    <= '0;
      elem_cnt_q <= '0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      lanes_q    <= lanes_d;
      elem_cnt_q <= elem_cnt_d;
      done_q     <= (state_q == S_DRAIN) && ps_valid_q && ps_last_q;
      cfg_err_q  <= (state_q == S_IDLE) && start_i && !lanes_legal;
    end
  end

  // Stage 1: masked lane products; idle cycles load zeros so the tree sum is 0 too.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      for (int k = 0; k < LANES; k++) prod_q[k] <= '0;
    end else begin
      s1_valid_q <= accept;
      s1_last_q  <= accept && beat_last;
      for (int k = 0; k < LANES; k++) begin
        prod_q[k] <= (accept && lane_used[k]) ?
                     (16'(a_i[8*k +: 8]) * 16'(b_i[8*k +: 8])) : 16'd0;
      end
    end
  end

`ifdef MAC_TREE_PIPE_EN
  logic [16:0] pair_q [LANES/2];
  logic        s2_valid_q, s2_last_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      for (int j = 0; j < LANES/2; j++) pair_q[j] <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
      for (int j = 0; j < LANES/2; j++) begin
        pair_q[j] <= 17'(prod_q[2*j]) + 17'(prod_q[2*j+1]);
      end
    end
  end

  always_comb begin
    tree_sum = '0;
    for (int j = 0; j < LANES/2; j++) tree_sum = tree_sum + W_IN'(pair_q[j]);
  end

  assign tail_valid = s2_valid_q;
  assign tail_last  = s2_last_q;
`else
  always_comb begin
    tree_sum = '0;
    for (int k = 0; k < LANES; k++) tree_sum = tree_sum + W_IN'(prod_q[k]);
  end

  assign tail_valid = s1_valid_q;
  assign tail_last  = s1_last_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ps_q       <= '0;
      ps_valid_q <= 1'b0;
      ps_last_q  <= 1'b0;
    end else begin
      ps_q       <= tail_valid ? tree_sum : '0;
      ps_valid_q <= tail_valid;
      ps_last_q  <= tail_valid && tail_last;
    end
  end

  assign ps_valid    = ps_valid_q;
  assign partial_sum = ps_q;
  assign ps_last     = ps_last_q;
  assign lanes_o     = lanes_q;
  assign done        = done_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_mac_lane_array.sv
// Bench for mac_lane_array: random and directed vectors checked against a per-element model
// that predicts every output cycle (sums, last tag, done, cfg_err).
module tb_mac_lane_array;
  localparam int ELEMS = 1000;
  localparam int LANES = 16;
  localparam int W_IN  = 20;
`ifdef MAC_TREE_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start_i = 1'b0;
  logic [4:0]           lanes_i = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [8*LANES-1:0]   a_i = '0;
  logic [8*LANES-1:0]   b_i = '0;
  logic                 ps_valid;
  logic [W_IN-1:0]      partial_sum;
  logic                 ps_last;
  logic [4:0]           lanes_o;
  logic                 busy;
  logic                 done;
  logic                 cfg_err;

  mac_lane_array #(.ELEMS(ELEMS), .LANES(LANES), .W_IN(W_IN)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .lanes_i(lanes_i),
    .in_valid(in_valid), .in_ready(in_ready), .a_i(a_i), .b_i(b_i),
    .ps_valid(ps_valid), .partial_sum(partial_sum), .ps_last(ps_last),
    .lanes_o(lanes_o), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int sum;
    bit last;
  } exp_t;

  exp_t    exp_q[$];
  int      cyc = 0;
  int      done_cyc = -1;
  int      cfg_cyc = -1;
  bit      mon_en = 1'b0;
  int      vec_ps_cnt = 0;
  longint  vec_ps_sum = 0;
  int      n_tests = 0;
  int      n_fail = 0;
  int      av[LANES];
  int      bv[LANES];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Cycle-exact output monitor driven by the expectation queue.
  always @(negedge clk) begin
    bit   ev;
    exp_t e;
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) void'(exp_q.pop_front());
      ev = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      chk("ps_valid", ps_valid, ev);
      if (ev) begin
        e = exp_q.pop_front();
        chk("partial_sum", partial_sum, e.sum);
        chk("ps_last", ps_last, e.last);
      end else begin
        chk("partial_sum_idle", partial_sum, 0);
        chk("ps_last_idle", ps_last, 0);
      end
      if (ps_valid) begin
        vec_ps_cnt++;
        vec_ps_sum += partial_sum;
      end
      chk("done", done, cyc == done_cyc);
      chk("cfg_err", cfg_err, cyc == cfg_cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int mode);
    for (int k = 0; k < LANES; k++) begin
      case (mode)
        0: begin av[k] = 255; bv[k] = 255; end
        1: begin av[k] = 1;   bv[k] = 1;   end
        2: begin av[k] = (k < 4) ? 1 : 255; bv[k] = av[k]; end
        3: begin av[k] = k + 1; bv[k] = 2; end
        default: begin av[k] = $urandom_range(0, 255); bv[k] = $urandom_range(0, 255); end
      endcase
      a_i[8*k +: 8] = 8'(av[k]);
      b_i[8*k +: 8] = 8'(bv[k]);
    end
  endtask

  // gap: 0 = back-to-back, 1 = valid every other cycle, 2 = random gaps. abort_beat<0: no abort.
  task automatic run_vector(input int lanes, input int mode, input int gap, input int abort_beat);
    int idx = 0;
    int beats = 0;
    int slot = 0;
    int s;
    bit v;
    tick();
    start_i = 1'b1;
    lanes_i = 5'(lanes);
    tick();
    start_i = 1'b0;
    vec_ps_cnt = 0;
    vec_ps_sum = 0;
    chk("busy_run", busy, 1);
    while (idx < ELEMS && slot < 8 * ELEMS) begin
      chk("in_ready_run", in_ready, 1);
      chk("lanes_o", lanes_o, lanes);
      if (beats == abort_beat) begin
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        exp_q.delete();
        done_cyc = -1;
        chk("abort_ps_valid", ps_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 0);
        rst_n = 1'b1;
        tick();
        return;
      end
      case (gap)
        0: v = 1'b1;
        1: v = (slot % 2) == 0;
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      fill(mode);
      start_i = ($urandom_range(0, 7) == 0);
      lanes_i = 5'($urandom_range(0, 31));
      in_valid = v;
      if (v) begin
        exp_t e;
        s = 0;
        for (int k = 0; k < lanes; k++)
          if (idx + k < ELEMS) s += av[k] * bv[k];
        e.cyc  = cyc + LAT;
        e.sum  = s;
        e.last = (idx + lanes >= ELEMS);
        exp_q.push_back(e);
        if (e.last) done_cyc = e.cyc + 1;
        idx += lanes;
        beats++;
      end
      slot++;
      tick();
    end
    in_valid = 1'b0;
    start_i  = 1'b0;
    chk("in_ready_drain", in_ready, 0);
    chk("busy_drain", busy, 1);
    repeat (LAT + 1) tick();
    chk("busy_after_done", busy, 0);
    chk("in_ready_idle", in_ready, 0);
    chk("beat_count", vec_ps_cnt, (ELEMS + lanes - 1) / lanes);
    tick();
  endtask

  initial begin
    int lv[5];
    int illegal[6];
    lv = '{1, 2, 4, 8, 16};
    illegal = '{3, 0, 5, 17, 31, 12};
    repeat (3) tick();
    mon_en = 1'b1;
    chk("rst_ps_valid", ps_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_lanes_o", lanes_o, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    tick();

    run_vector(1, 0, 0, -1);
    run_vector(16, 1, 0, -1);
    run_vector(4, 2, 0, -1);

    foreach (illegal[i]) begin
      start_i = 1'b1;
      lanes_i = 5'(illegal[i]);
      cfg_cyc = cyc + 1;
      tick();
      start_i = 1'b0;
      chk("cfg_busy", busy, 0);
      chk("cfg_in_ready", in_ready, 0);
      tick();
    end

    run_vector(8, 3, 1, -1);

    run_vector(16, 0, 0, 30);
    run_vector(16, 0, 0, -1);
    chk("golden_sum", vec_ps_sum, 64'(ELEMS) * 255 * 255);

    for (int r = 0; r < 4; r++) run_vector(lv[$urandom_range(1, 4)], 4, 2, -1);
    run_vector(2, 4, 2, -1);

    repeat (4) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule
